spi_ram_ctrl: RTL

//   Parametrised command-driven RAM slave behind the SPI slave shifter. It decodes
//   {cmd[1:0], payload} words from the SPI front end, keeps separate write and read

---
 rtl/spi_ram_pkg.sv | 12 +
 rtl/spi_ram_mem.sv | 36 +++
 rtl/spi_ram_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command codes and FSM state encoding for the SPI RAM controller.
package spi_ram_pkg;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_TX_HOLD = 1'b1
    } state_e;
endpackage

// File: rtl/spi_ram_mem.sv
// Word-wide RAM: synchronous write port, registered read port that can load zero
// for out-of-range reads. Only the read register is reset; the array is not.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rclr,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = rclr ? '0 : mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for the SPI RAM slave: write/read pointers, range checking,
// and a two-state result holder that backpressures the SPI front end.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              addr_err
);
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH;
    endfunction

    // Out-of-range pointers keep counting and only wrap on natural overflow.
    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] a);
        if (AUTO_INC == 0) return a;
        return (a == LAST) ? '0 : a + ADDR_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              addr_err_q, addr_err_d;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] pay_addr;
    logic [DATA_W-1:0] pay_data;
    logic              accept, xfer, mem_we, mem_re, mem_rclr;

    assign cmd      = din[DATA_W+1:DATA_W];
    assign pay_data = din[DATA_W-1:0];
    assign pay_addr = din[ADDR_W-1:0];
    assign tx_valid = (state_q == ST_TX_HOLD);
    assign rx_ready = ~tx_valid | tx_ready;
    assign accept   = rx_valid & rx_ready;
    assign xfer     = tx_valid & tx_ready;
    assign addr_err = addr_err_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_rclr   = 1'b0;
        if (xfer) state_d = ST_IDLE;
        if (accept) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_ptr_d   = pay_addr;
                    addr_err_d = ~in_range(pay_addr);
                end
                CMD_WR_DATA: begin
                    mem_we     = in_range(wr_ptr_q);
                    addr_err_d = ~in_range(wr_ptr_q);
                    wr_ptr_d   = ptr_next(wr_ptr_q);
                end
                CMD_RD_ADDR: begin
                    rd_ptr_d   = pay_addr;
                    addr_err_d = ~in_range(pay_addr);
                end
                default: begin
                    // A read accepted alongside an xfer reloads dout and stays in hold.
                    mem_re     = 1'b1;
                    mem_rclr   = ~in_range(rd_ptr_q);
                    addr_err_d = ~in_range(rd_ptr_q);
                    rd_ptr_d   = ptr_next(rd_ptr_q);
                    state_d    = ST_TX_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    spi_ram_mem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (mem_we),
        .waddr(wr_ptr_q),
        .wdata(pay_data),
        .re   (mem_re),
        .rclr (mem_rclr),
        .raddr(rd_ptr_q),
        .rdata(dout)
    );
endmodule
